// File: rtl/score_pkg.sv
// Shared constants, state encoding and scoring helpers for the score keeper.
// Imported by the debouncer and the top-level scoreboard controller.
package score_pkg;

   typedef enum logic [1:0] {
      ST_SETUP = 2'b00,
      ST_PLAY  = 2'b01,
      ST_FINAL = 2'b10
   } game_state_e;

   localparam int         DEB_CYC_DEFAULT = 1_000_000;
   localparam logic [7:0] MAX_SCORE       = 8'd99;
   localparam logic [1:0] LAST_PERIOD     = 2'd3;

   localparam logic [7:0] TEAM_PAIR0 = 8'hAB;
   localparam logic [7:0] TEAM_PAIR1 = 8'hCD;
   localparam logic [7:0] TEAM_PAIR2 = 8'hEF;

   // Nine bits keep score + pv from wrapping before the clamp.
   function automatic logic [7:0] sat_add(input logic [7:0] score, input logic [1:0] pv);
      logic [8:0] sum;
      logic [7:0] res;
      sum = {1'b0, score} + {7'b0, pv};
      if (sum > {1'b0, MAX_SCORE}) res = MAX_SCORE;
      else                         res = sum[7:0];
      return res;
   endfunction

   function automatic logic [7:0] next_team(input logic [7:0] team);
      logic [7:0] res;
      case (team)
         TEAM_PAIR0: res = TEAM_PAIR1;
         TEAM_PAIR1: res = TEAM_PAIR2;
         default:    res = TEAM_PAIR0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button channel: 2-FF synchronizer, stability counter and a
// single-cycle press pulse on each released->pressed transition.
module key_debounce
   import score_pkg::*;
#(
   parameter int DEB_CYC = DEB_CYC_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n_i,
   output logic press_o
);

   localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC + 1) : 1;

   logic          meta_q, sync_q, level_q, press_q;
   logic          level_d, press_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Any cycle where the synchronized input matches the level restarts the count.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      press_d = 1'b0;
      if (sync_q != level_q) begin
         if (cnt_q == CW'(DEB_CYC - 1)) begin
            level_d = sync_q;
            press_d = ~sync_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q  <= 1'b1;
         sync_q  <= 1'b1;
         level_q <= 1'b1;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         meta_q  <= key_n_i;
         sync_q  <= meta_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/score_keeper.sv
// Basketball-style score keeper: five debounced keys drive a SETUP/PLAY/FINAL
// game FSM whose registered outputs feed the lcd1602 driver directly.
module score_keeper
   import score_pkg::*;
#(
   parameter int DEB_CYC = DEB_CYC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        key_a,
   input  logic        key_b,
   input  logic        key_pts,
   input  logic        key_next,
   input  logic        key_team,
   output logic [17:0] disp_lcd,
   output logic [7:0]  team_name,
   output logic [2:0]  pts_led,
   output logic [1:0]  game_state
);

   localparam int NKEYS = 5;

   // Bit order: 0 a, 1 b, 2 pts, 3 next, 4 team.
   logic [NKEYS-1:0] keys_raw;
   logic [NKEYS-1:0] press;

   assign keys_raw = {key_team, key_next, key_pts, key_b, key_a};

   for (genvar gi = 0; gi < NKEYS; gi++) begin : g_key
      key_debounce #(
         .DEB_CYC (DEB_CYC)
      ) u_key_debounce (
         .clk     (clk),
         .rst_n   (rst_n),
         .key_n_i (keys_raw[gi]),
         .press_o (press[gi])
      );
   end

   game_state_e state_q, state_d;
   logic [1:0]  period_q, period_d;
   logic [7:0]  home_q, home_d;
   logic [7:0]  guest_q, guest_d;
   logic [7:0]  team_q, team_d;
   logic [2:0]  pts_q, pts_d;
   logic [1:0]  pv;

   // Adds use the point value held before any same-cycle key_pts rotation.
   assign pv = pts_q[2] ? 2'd3 : (pts_q[1] ? 2'd2 : 2'd1);

   always_comb begin
      state_d  = state_q;
      period_d = period_q;
      home_d   = home_q;
      guest_d  = guest_q;
      team_d   = team_q;
      pts_d    = pts_q;

      if (press[2]) pts_d = {pts_q[1:0], pts_q[2]};

      case (state_q)
         ST_SETUP: begin
            if (press[4]) team_d  = next_team(team_q);
            if (press[3]) state_d = ST_PLAY;
         end
         ST_PLAY: begin
            if (press[0]) home_d  = sat_add(home_q, pv);
            if (press[1]) guest_d = sat_add(guest_q, pv);
            if (press[3]) begin
               if (period_q == LAST_PERIOD) state_d  = ST_FINAL;
               else                         period_d = period_q + 2'd1;
            end
         end
         ST_FINAL: begin
         end
         default: state_d = ST_SETUP;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_SETUP;
         period_q <= 2'd0;
         home_q   <= 8'd0;
         guest_q  <= 8'd0;
         team_q   <= TEAM_PAIR0;
         pts_q    <= 3'b001;
      end else begin
         state_q  <= state_d;
         period_q <= period_d;
         home_q   <= home_d;
         guest_q  <= guest_d;
         team_q   <= team_d;
         pts_q    <= pts_d;
      end
   end

   assign disp_lcd   = {period_q, guest_q, home_q};
   assign team_name  = team_q;
   assign pts_led    = pts_q;
   assign game_state = state_q;

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: stimulus pushes model predictions with a
// due cycle, a monitor applies them and compares the outputs every cycle.
module tb_score_keeper;

   localparam int DEB = 4;

   logic        clk;
   logic        rst_n;
   logic [4:0]  keys_n;
   logic [17:0] disp_lcd;
   logic [7:0]  team_name;
   logic [2:0]  pts_led;
   logic [1:0]  game_state;

   score_keeper #(.DEB_CYC(DEB)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_a      (keys_n[0]),
      .key_b      (keys_n[1]),
      .key_pts    (keys_n[2]),
      .key_next   (keys_n[3]),
      .key_team   (keys_n[4]),
      .disp_lcd   (disp_lcd),
      .team_name  (team_name),
      .pts_led    (pts_led),
      .game_state (game_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [31:0] due;
      logic [17:0] disp;
      logic [7:0]  team;
      logic [2:0]  pts;
      logic [1:0]  gs;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   exp_t  cur_exp;
   string cur_name = "reset";
   bit    armed = 0;
   int    checks = 0;
   int    errors = 0;

   // ---------------- reference model (game rules in plain integers) -------
   int m_state, m_period, m_home, m_guest, m_pv, m_pair;

   function automatic void model_reset();
      m_state = 0; m_period = 0; m_home = 0; m_guest = 0; m_pv = 1; m_pair = 0;
   endfunction

   function automatic int cap(input int v);
      return (v > 99) ? 99 : v;
   endfunction

   function automatic void model_apply(input logic [4:0] m);
      int pv_old;
      pv_old = m_pv;
      if (m[2]) m_pv = (m_pv == 3) ? 1 : m_pv + 1;
      if (m_state == 0) begin
         if (m[4]) m_pair = (m_pair + 1) % 3;
         if (m[3]) m_state = 1;
      end else if (m_state == 1) begin
         if (m[0]) m_home  = cap(m_home + pv_old);
         if (m[1]) m_guest = cap(m_guest + pv_old);
         if (m[3]) begin
            if (m_period < 3) m_period = m_period + 1;
            else              m_state = 2;
         end
      end
   endfunction

   function automatic exp_t model_out(input int due);
      exp_t e;
      logic [7:0] codes [3];
      codes[0] = 8'hAB; codes[1] = 8'hCD; codes[2] = 8'hEF;
      e.due  = due;
      e.disp = {2'(m_period), 8'(m_guest), 8'(m_home)};
      e.team = codes[m_pair];
      e.pts  = 3'(1 << (m_pv - 1));
      e.gs   = 2'(m_state);
      return e;
   endfunction

   // ---------------- monitor ----------------------------------------------
   task automatic compare(input string nm, input exp_t e);
      checks++;
      if (disp_lcd !== e.disp || team_name !== e.team || pts_led !== e.pts || game_state !== e.gs) begin
         errors++;
         $display("FAIL %s cyc=%0d got disp=%h team=%h pts=%b gs=%b expected disp=%h team=%h pts=%b gs=%b",
                  nm, cyc, disp_lcd, team_name, pts_led, game_state, e.disp, e.team, e.pts, e.gs);
      end
   endtask

   always @(negedge rst_n) begin
      exp_q.delete();
      name_q.delete();
      cur_exp.due  = 0;
      cur_exp.disp = 18'h0;
      cur_exp.team = 8'hAB;
      cur_exp.pts  = 3'b001;
      cur_exp.gs   = 2'b00;
      cur_name     = "reset_async";
      armed        = 1;
      #1;
      compare(cur_name, cur_exp);
   end

   always @(negedge clk) begin
      if (armed) begin
         if (exp_q.size() > 0 && int'(exp_q[0].due) <= cyc) begin
            cur_exp  = exp_q.pop_front();
            cur_name = name_q.pop_front();
            $display("cyc=%0d %s disp=%h team=%h pts=%b gs=%b", cyc, cur_name,
                     cur_exp.disp, cur_exp.team, cur_exp.pts, cur_exp.gs);
         end
         compare(cur_name, cur_exp);
      end
   end

   // ---------------- stimulus ---------------------------------------------
   task automatic push(input int due, input string nm);
      exp_q.push_back(model_out(due));
      name_q.push_back(nm);
   endtask

   // Clean press: low long enough to debounce, then released until stable.
   task automatic press(input logic [4:0] m, input string nm);
      @(posedge clk); #1;
      keys_n = ~m;
      model_apply(m);
      push(cyc + 3 + DEB, nm);
      repeat (DEB + 4) @(posedge clk);
      #1 keys_n = '1;
      repeat (DEB + 6) @(posedge clk);
   endtask

   task automatic do_reset(input logic [4:0] held);
      @(posedge clk); #3;
      keys_n = ~held;
      rst_n  = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      if (held != 5'b0) begin
         model_apply(held);
         push(cyc + 3 + DEB, "hold_through_reset");
         repeat (DEB + 4) @(posedge clk);
         #1 keys_n = '1;
         repeat (DEB + 6) @(posedge clk);
      end
   endtask

   initial begin
      keys_n = '1;
      rst_n  = 1'b1;
      model_reset();
      #2 rst_n = 1'b0;
      #1 keys_n[4] = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      model_apply(5'h10);
      push(cyc + 3 + DEB, "team_held_through_reset");
      repeat (DEB + 4) @(posedge clk);
      #1 keys_n = '1;
      repeat (DEB + 6) @(posedge clk);

      press(5'h10, "setup_team");
      press(5'h10, "setup_team_wrap");
      press(5'h08, "start_play");
      press(5'h10, "play_team_ignored");

      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1 keys_n[0] = 1'b0;
         repeat (3) @(posedge clk);
         #1 keys_n[0] = 1'b1;
         repeat (3) @(posedge clk);
      end
      repeat (DEB + 6) @(posedge clk);

      press(5'h04, "pts_to_2");
      press(5'h04, "pts_to_3");
      for (int i = 0; i < 3; i++) press(5'h01, "home_plus3");
      press(5'h04, "pts_to_1");
      press(5'h02, "guest_plus1");

      press(5'h04, "pts_to_2");
      press(5'h04, "pts_to_3");
      for (int i = 0; i < 29; i++) press(5'h01, "home_climb");
      press(5'h04, "pts_to_1");
      press(5'h04, "pts_to_2");
      press(5'h01, "home_98");
      press(5'h04, "pts_to_3");
      press(5'h01, "home_sat_99");
      press(5'h01, "home_stays_99");

      for (int i = 0; i < 4; i++) press(5'h08, "period_walk");
      press(5'h01, "final_a_ignored");
      press(5'h02, "final_b_ignored");
      press(5'h18, "final_next_team_ignored");
      press(5'h04, "final_pts_moves");

      do_reset(5'h00);
      press(5'h08, "start_play");
      press(5'h04, "pts_to_2");
      press(5'h04, "pts_to_3");
      for (int i = 0; i < 6; i++) press(5'h01, "home_to_18");
      press(5'h04, "pts_to_1");
      press(5'h04, "pts_to_2");
      press(5'h01, "home_20");
      press(5'h04, "pts_to_3");
      for (int i = 0; i < 5; i++) press(5'h02, "guest_to_15");
      press(5'h08, "period_1");
      press(5'h08, "period_2");

      // Reset in the middle of a key_a debounce: no pulse may survive it.
      @(posedge clk); #1 keys_n[0] = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 keys_n = '1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (DEB + 8) @(posedge clk);
      press(5'h08, "play_after_reset");

      for (int i = 0; i < 80; i++) begin
         logic [4:0] m;
         if ($urandom_range(0, 11) == 0) begin
            do_reset($urandom_range(0, 3) == 0 ? 5'h10 : 5'h00);
         end else begin
            m[2:0] = 3'($urandom_range(0, 7));
            m[3]   = ($urandom_range(0, 5) == 0);
            m[4]   = ($urandom_range(0, 3) == 0);
            if (m == 5'h0) m = 5'h01;
            press(m, "random");
         end
      end

      repeat (DEB + 10) @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout cyc=%0d required=finish", cyc);
      $fatal(1, "timeout");
   end

endmodule
